// File: rtl/ps2_pkg.sv
// Shared constants and FSM state type for the PS/2 key event encoder.
package ps2_pkg;

   localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_REL   = 8'hF0;
   localparam logic [7:0] PS2_PREFIX_PAUSE = 8'hE1;
   localparam logic [2:0] PS2_PAUSE_SKIP   = 3'd7;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_t;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter for one PS/2 line.
// The filtered output changes only after FILTER_LEN consecutive differing samples.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic raw,
   output logic filtered
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [1:0]    sync;
   logic [CW-1:0] run_cnt;

   // The run counter restarts whenever the synchronized sample agrees with the output.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         sync     <= 2'b11;
         run_cnt  <= '0;
         filtered <= 1'b1;
      end else begin
         sync <= {sync[0], raw};
         if (sync[1] == filtered) begin
            run_cnt <= '0;
         end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
            filtered <= sync[1];
            run_cnt  <= '0;
         end else begin
            run_cnt <= run_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 receive FSM and scancode decoder producing the toggle-flagged ps2_key event word.
module ps2_key_encoder
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 48000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          clk_f;
   logic          data_f;
   logic          clk_prev;
   logic          strobe;
   ps2_state_t    state;
   ps2_state_t    state_next;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_reg;
   logic          par_bit;
   logic          parity_ok;
   logic [TW-1:0] timeout_cnt;
   logic          timeout_hit;
   logic          ext_flag;
   logic          rel_flag;
   logic [2:0]    skip_cnt;
   logic          shift_en;
   logic          par_en;
   logic          start_err;
   logic          stop_ok;
   logic          stop_bad;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) clk_filter (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .raw      (ps2_clk),
      .filtered (clk_f)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) data_filter (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .raw      (ps2_data),
      .filtered (data_f)
   );

   assign strobe      = clk_prev & ~clk_f;
   assign parity_ok   = ^{shift_reg, par_bit};
   assign timeout_hit = (state != IDLE) && (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Timeout has priority, so a strobe landing on the expiry cycle is dropped.
   always_comb begin
      state_next = state;
      shift_en   = 1'b0;
      par_en     = 1'b0;
      start_err  = 1'b0;
      stop_ok    = 1'b0;
      stop_bad   = 1'b0;
      if (timeout_hit) begin
         state_next = IDLE;
      end else if (strobe) begin
         case (state)
            IDLE: begin
               if (data_f) begin
                  start_err = 1'b1;
               end else begin
                  state_next = DATA;
               end
            end
            DATA: begin
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) begin
                  state_next = PARITY;
               end
            end
            PARITY: begin
               par_en     = 1'b1;
               state_next = STOP;
            end
            STOP: begin
               if (data_f && parity_ok) begin
                  stop_ok = 1'b1;
               end else begin
                  stop_bad = 1'b1;
               end
               state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         clk_prev    <= 1'b1;
         bit_cnt     <= 3'd0;
         shift_reg   <= 8'h00;
         par_bit     <= 1'b0;
         timeout_cnt <= '0;
         frame_err   <= 1'b0;
      end else begin
         clk_prev  <= clk_f;
         frame_err <= timeout_hit | start_err | stop_bad;
         if (shift_en) begin
            shift_reg <= {data_f, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
         end else if (state == IDLE) begin
            bit_cnt <= 3'd0;
         end
         if (par_en) begin
            par_bit <= data_f;
         end
         if (state == IDLE || strobe) begin
            timeout_cnt <= '0;
         end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
         end
      end
   end

   // Prefix bytes only arm flags; every other accepted byte emits one event and consumes them.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         ps2_key  <= 11'h000;
         ext_flag <= 1'b0;
         rel_flag <= 1'b0;
         skip_cnt <= 3'd0;
      end else if (timeout_hit || stop_bad) begin
         ext_flag <= 1'b0;
         rel_flag <= 1'b0;
      end else if (stop_ok) begin
         if (skip_cnt != 3'd0) begin
            skip_cnt <= skip_cnt - 3'd1;
            if (skip_cnt == 3'd1) begin
               ext_flag <= 1'b0;
               rel_flag <= 1'b0;
            end
         end else begin
            case (shift_reg)
               PS2_PREFIX_EXT:   ext_flag <= 1'b1;
               PS2_PREFIX_REL:   rel_flag <= 1'b1;
               PS2_PREFIX_PAUSE: skip_cnt <= PS2_PAUSE_SKIP;
               default: begin
                  ps2_key  <= {~ps2_key[10], ~rel_flag, ext_flag, shift_reg};
                  ext_flag <= 1'b0;
                  rel_flag <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
